// File: rtl/decoder_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_pipe
//  Purpose  : Registered binary-to-vector decoder (one-hot / thermometer-up /
//             thermometer-down / all-zero) behind a valid/ready handshake,
//             with a 2-entry skid buffer so one decode per cycle is sustained
//             under downstream backpressure.
//  Option   : DECODER_PIPE_RANGE_CHK_EN -- when defined, idx >= OUT_W yields a
//             zero vector plus out_err = 1, and the error bit is stored with
//             its vector. When undefined, out_err is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module decoder_pipe #(
  parameter int IN_W  = 7,
  parameter int OUT_W = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_idx,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_vec,
  output logic             out_err
);

  localparam logic [1:0] c_MODE_ONEHOT = 2'b00;
  localparam logic [1:0] c_MODE_THUP   = 2'b01;
  localparam logic [1:0] c_MODE_THDN   = 2'b10;

  // Combinational decode of the incoming request
  logic [OUT_W-1:0] dec_vec;
  logic             dec_err;

  // Main (output) entry and skid entry
  logic [OUT_W-1:0] main_vec_q, main_vec_d;
  logic             main_vld_q, main_vld_d;
  logic [OUT_W-1:0] skid_vec_q, skid_vec_d;
  logic             skid_vld_q, skid_vld_d;
  logic             in_ready_q, in_ready_d;
`ifdef DECODER_PIPE_RANGE_CHK_EN
  logic             main_err_q, main_err_d;
  logic             skid_err_q, skid_err_d;
`endif

  logic accept;
  logic drain;

  // Per-bit decode; an out-of-range index falls out of the compares naturally
  always_comb begin
    dec_vec = '0;
    dec_err = 1'b0;
    for (int i = 0; i < OUT_W; i++) begin
      case (in_mode)
        c_MODE_ONEHOT: dec_vec[i] = (int'(in_idx) == i);
        c_MODE_THUP:   dec_vec[i] = (i <= int'(in_idx));
        c_MODE_THDN:   dec_vec[i] = (i >= int'(in_idx));
        default:       dec_vec[i] = 1'b0;
      endcase
    end
`ifdef DECODER_PIPE_RANGE_CHK_EN
    if (int'(in_idx) >= OUT_W) begin
      dec_vec = '0;
      dec_err = 1'b1;
    end
`endif
  end

  assign accept = in_valid && in_ready_q;
  assign drain  = main_vld_q && out_ready;

  // Next-state of the two entries: FIFO order, skid refills main on drain
  always_comb begin
    main_vec_d = main_vec_q;
    main_vld_d = main_vld_q;
    skid_vec_d = skid_vec_q;
    skid_vld_d = skid_vld_q;
`ifdef DECODER_PIPE_RANGE_CHK_EN
    main_err_d = main_err_q;
    skid_err_d = skid_err_q;
`endif
    if (drain) begin
      if (skid_vld_q) begin
        // in_ready is low while the skid is full, so no accept can coincide
        main_vec_d = skid_vec_q;
        skid_vld_d = 1'b0;
`ifdef DECODER_PIPE_RANGE_CHK_EN
        main_err_d = skid_err_q;
`endif
      end else if (accept) begin
        main_vec_d = dec_vec;
`ifdef DECODER_PIPE_RANGE_CHK_EN
        main_err_d = dec_err;
`endif
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_vld_q) begin
        main_vec_d = dec_vec;
        main_vld_d = 1'b1;
`ifdef DECODER_PIPE_RANGE_CHK_EN
        main_err_d = dec_err;
`endif
      end else begin
        skid_vec_d = dec_vec;
        skid_vld_d = 1'b1;
`ifdef DECODER_PIPE_RANGE_CHK_EN
        skid_err_d = dec_err;
`endif
      end
    end
    // Ready tracks "skid empty" but from a register, so out_ready never
    // reaches in_ready combinationally
    in_ready_d = !skid_vld_d;
  end

  // State registers with synchronous reset discarding both entries
  always_ff @(posedge clk) begin
    if (rst) begin
      main_vec_q <= '0;
      main_vld_q <= 1'b0;
      skid_vec_q <= '0;
      skid_vld_q <= 1'b0;
      in_ready_q <= 1'b0;
`ifdef DECODER_PIPE_RANGE_CHK_EN
      main_err_q <= 1'b0;
      skid_err_q <= 1'b0;
`endif
    end else begin
      main_vec_q <= main_vec_d;
      main_vld_q <= main_vld_d;
      skid_vec_q <= skid_vec_d;
      skid_vld_q <= skid_vld_d;
      in_ready_q <= in_ready_d;
`ifdef DECODER_PIPE_RANGE_CHK_EN
      main_err_q <= main_err_d;
      skid_err_q <= skid_err_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_vld_q;
  assign out_vec   = main_vec_q;
`ifdef DECODER_PIPE_RANGE_CHK_EN
  assign out_err   = main_err_q;
`else
  assign out_err   = 1'b0;
  // dec_err is constant 0 without the range check; keep it consumed
  logic unused_dec_err;
  assign unused_dec_err = dec_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decoder_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decoder_pipe
//  Purpose  : Self-checking bench for decoder_pipe. Drives a wide instance
//             (IN_W=7, OUT_W=128) and a narrow one (IN_W=3, OUT_W=6) with the
//             same handshake, and compares both against a depth-2 FIFO model
//             whose entries are computed arithmetically from the decode rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_pipe;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [6:0]   in_idx;
  logic [1:0]   in_mode;
  logic         out_ready;

  logic         in_ready_w, out_valid_w, out_err_w;
  logic [127:0] out_vec_w;
  logic         in_ready_n, out_valid_n, out_err_n;
  logic [5:0]   out_vec_n;

  int n_cmp;
  int n_err;

  // Model state: results in flight, plus whether ready is allowed yet
  logic [128:0] q_w[$];
  logic [128:0] q_n[$];
  bit           rdy_en;
  bit           fresh;

  decoder_pipe #(.IN_W(7), .OUT_W(128)) u_dut_w (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_w),
    .in_idx(in_idx), .in_mode(in_mode),
    .out_valid(out_valid_w), .out_ready(out_ready),
    .out_vec(out_vec_w), .out_err(out_err_w)
  );

  decoder_pipe #(.IN_W(3), .OUT_W(6)) u_dut_n (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_n),
    .in_idx(in_idx[2:0]), .in_mode(in_mode),
    .out_valid(out_valid_n), .out_ready(out_ready),
    .out_vec(out_vec_n), .out_err(out_err_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected {err, vec} from the decode rules, using plain arithmetic
  function automatic logic [128:0] ref_dec(input int idx, input int mode, input int ow);
    logic [128:0] mask;
    logic [128:0] v;
    mask = (129'd1 << ow) - 129'd1;
    v = '0;
`ifdef DECODER_PIPE_RANGE_CHK_EN
    if (idx >= ow) return {1'b1, 128'd0};
`endif
    case (mode)
      0: v = (idx < ow) ? (129'd1 << idx) : 129'd0;
      1: v = (idx < ow) ? ((129'd2 << idx) - 129'd1) : mask;
      2: v = (idx < ow) ? (mask & ~((129'd1 << idx) - 129'd1)) : 129'd0;
      default: v = '0;
    endcase
    return {1'b0, v[127:0] & mask[127:0]};
  endfunction

  // One cycle: check outputs (stable after negedge), drive, advance model
  task automatic step(input logic v, input int idx, input int mode,
                      input logic ordy, input logic r, output bit acc);
    bit exp_rdy;
    exp_rdy = rdy_en && (q_w.size() < 2);
    check("w.out_valid", {127'd0, out_valid_w}, {127'd0, q_w.size() > 0});
    check("w.in_ready",  {127'd0, in_ready_w},  {127'd0, exp_rdy});
    check("n.out_valid", {127'd0, out_valid_n}, {127'd0, q_n.size() > 0});
    check("n.in_ready",  {127'd0, in_ready_n},  {127'd0, exp_rdy});
    if (q_w.size() > 0) begin
      check("w.out_vec", out_vec_w, q_w[0][127:0]);
      check("w.out_err", {127'd0, out_err_w}, {127'd0, q_w[0][128]});
      check("n.out_vec", {122'd0, out_vec_n}, q_n[0][127:0]);
      check("n.out_err", {127'd0, out_err_n}, {127'd0, q_n[0][128]});
    end else if (fresh) begin
      check("w.reset_vec", out_vec_w, 128'd0);
      check("w.reset_err", {127'd0, out_err_w}, 128'd0);
      check("n.reset_vec", {122'd0, out_vec_n}, 128'd0);
    end
    rst       = r;
    in_valid  = v;
    in_idx    = 7'(idx);
    in_mode   = 2'(mode);
    out_ready = ordy;
    acc = v && exp_rdy && !r;
    @(negedge clk);
    if (r) begin
      q_w.delete();
      q_n.delete();
      rdy_en = 1'b0;
      fresh  = 1'b1;
    end else begin
      if (ordy && q_w.size() > 0) begin
        void'(q_w.pop_front());
        void'(q_n.pop_front());
      end
      if (acc) begin
        q_w.push_back(ref_dec(idx, mode, 128));
        q_n.push_back(ref_dec(idx & 7, mode, 6));
        fresh = 1'b0;
      end
      rdy_en = 1'b1;
    end
  endtask

  // Hold one request until accepted, within a cycle budget
  task automatic send(input int idx, input int mode, input logic ordy);
    bit acc;
    int k;
    acc = 1'b0;
    k = 0;
    while (!acc && k < 20) begin
      step(1'b1, idx, mode, ordy, 1'b0, acc);
      k++;
    end
    if (!acc) check("send_timeout", 128'd0, 128'd1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b1, 1'b0, acc);
  endtask

  initial begin
    bit acc;
    int sent;
    int cyc;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_idx = '0;
    in_mode = '0;
    out_ready = 1'b1;
    rdy_en = 1'b0;
    fresh = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // Reset state observed, then release
    step(1'b0, 0, 0, 1'b1, 1'b0, acc);

    // One-hot at the corners, thermometers, all-zero mode
    send(0, 0, 1'b1);
    send(1, 0, 1'b1);
    send(64, 0, 1'b1);
    send(127, 0, 1'b1);
    send(3, 1, 1'b1);
    send(124, 2, 1'b1);
    send(93, 3, 1'b1);
    // Narrow instance out-of-range: one-hot and thermometer-up at idx 7
    send(7, 0, 1'b1);
    send(7, 1, 1'b1);
    send(6, 2, 1'b1);
    idle(2);

    // Back-to-back stream 0..9 with a downstream stall in cycles 2-5
    sent = 0;
    cyc = 0;
    while (sent < 10 && cyc < 40) begin
      step(1'b1, sent, 0, !(cyc >= 2 && cyc <= 5), 1'b0, acc);
      if (acc) sent++;
      cyc++;
    end
    if (sent != 10) check("stream_timeout", 128'(sent), 128'd10);
    idle(3);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      step(1'b1 & ($urandom_range(0, 3) != 0), int'($urandom_range(0, 127)),
           int'($urandom_range(0, 3)), $urandom_range(0, 2) != 0, 1'b0, acc);
    end
    idle(3);

    // Fill both entries, then reset mid-operation
    cyc = 0;
    while (q_w.size() < 2 && cyc < 10) begin
      step(1'b1, int'($urandom_range(0, 127)), 0, 1'b0, 1'b0, acc);
      cyc++;
    end
    if (q_w.size() != 2) check("fill_timeout", 128'(q_w.size()), 128'd2);
    step(1'b0, 0, 0, 1'b0, 1'b1, acc);
    step(1'b0, 0, 0, 1'b1, 1'b0, acc);
    step(1'b0, 0, 0, 1'b1, 1'b0, acc);
    send(5, 1, 1'b1);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
